udp_box_packer: RTL and testbench

Byte-to-record packer between the UDP receive path and `udp_unpack_720p`. It parses box-list packets from the UDP payload byte stream and assembles 6-byte big-endian records into 48-bit box words. Records are stored in a double-buffered box table, and a completed list is presented to the video side at the next frame boundary. Each read word is fed directly to `udp_unpack_720p.i_data`.

---
 rtl/udp_box_packer.sv | 189 ++++++++++++++++++
 tb/tb_udp_box_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_box_packer.sv
// Box-list packet parser: packs 6-byte records into a double-buffered table.
// Optional statistics counters are enabled with UDP_BOX_PACKER_STATS_EN.
module udp_box_packer #(
  parameter int          MAX_BOXES = 16,
  parameter logic [7:0]  MAGIC     = 8'hA5,
  localparam int         IW = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          udp_valid,
  input  logic [7:0]    udp_data,
  input  logic          udp_last,
  input  logic          vsync,
  input  logic [IW-1:0] rd_idx,
  output logic [47:0]   o_data,
  output logic [7:0]    o_count,
  output logic          o_err,
  output logic          o_drop,
  output logic [15:0]   o_pkt_cnt,
  output logic [15:0]   o_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE, S_COUNT, S_PAYLOAD, S_DRAIN
  } state_t;

  localparam logic [7:0] MAXB = 8'(MAX_BOXES);

  state_t      r_state;
  logic        r_front;
  logic        r_pending;
  logic [7:0]  r_cnt_back;
  logic [7:0]  r_n;
  logic [2:0]  r_bcnt;
  logic [7:0]  r_widx;
  logic [39:0] r_sr;
  logic [7:0]  r_count;
  logic [47:0] r_data;
  logic        r_err;
  logic        r_drop;
  logic [47:0] r_mem [2][MAX_BOXES];

  logic [47:0] w_word;
  logic        w_we;
  logic        w_last_rec;
  logic        w_commit;
  logic [8:0]  w_ridx;
  logic        w_rd_ok;

  assign w_word     = {r_sr, udp_data};
  assign w_we       = udp_valid && (r_state == S_PAYLOAD)
                      && (r_bcnt == 3'd5);
  assign w_last_rec = (r_widx == r_n - 8'd1);
  assign w_commit   = w_we && w_last_rec && udp_last;
  assign w_ridx     = 9'(rd_idx);
  assign w_rd_ok    = (w_ridx < {1'b0, r_count})
                      && (w_ridx < 9'(MAX_BOXES));

  // Table storage carries no reset; o_count masks stale entries.
  always_ff @(posedge clk) begin
    if (w_we)
      r_mem[~r_front][r_widx[IW-1:0]] <= w_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_data <= '0;
    else
      r_data <= w_rd_ok ? r_mem[r_front][rd_idx] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_front    <= 1'b0;
      r_pending  <= 1'b0;
      r_cnt_back <= '0;
      r_n        <= '0;
      r_bcnt     <= '0;
      r_widx     <= '0;
      r_sr       <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;
      if (vsync && r_pending) begin
        r_front   <= ~r_front;
        r_count   <= r_cnt_back;
        r_pending <= 1'b0;
      end
      if (udp_valid) begin
        unique case (r_state)
          S_IDLE: begin
            if (udp_data == MAGIC) begin
              if (r_pending) begin
                r_drop  <= 1'b1;
                r_state <= udp_last ? S_IDLE : S_DRAIN;
              end else if (udp_last) begin
                r_err <= 1'b1;
              end else begin
                r_state <= S_COUNT;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= udp_last ? S_IDLE : S_DRAIN;
            end
          end
          S_COUNT: begin
            if (udp_data == 8'd0 || udp_data > MAXB) begin
              r_err   <= 1'b1;
              r_state <= udp_last ? S_IDLE : S_DRAIN;
            end else if (udp_last) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_n     <= udp_data;
              r_bcnt  <= '0;
              r_widx  <= '0;
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_sr <= {r_sr[31:0], udp_data};
            if (r_bcnt == 3'd5) begin
              r_bcnt <= '0;
              r_widx <= r_widx + 8'd1;
              if (w_last_rec) begin
                if (udp_last) begin
                  r_cnt_back <= r_n;
                  r_pending  <= 1'b1;
                  r_state    <= S_IDLE;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= S_DRAIN;
                end
              end else if (udp_last) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_bcnt <= r_bcnt + 3'd1;
              if (udp_last) begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
          S_DRAIN: begin
            if (udp_last)
              r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_data  = r_data;
  assign o_count = r_count;
  assign o_err   = r_err;
  assign o_drop  = r_drop;

`ifdef UDP_BOX_PACKER_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_commit && r_pkt_cnt != 16'hFFFF)
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if ((r_err || r_drop) && r_err_cnt != 16'hFFFF)
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_pkt_cnt = r_pkt_cnt;
  assign o_err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused  = w_commit;
  assign o_pkt_cnt = '0;
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_udp_box_packer.sv
// Directed bench for udp_box_packer with a read-data scoreboard.
module tb_udp_box_packer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        udp_valid;
  logic [7:0]  udp_data;
  logic        udp_last;
  logic        vsync;
  logic [3:0]  rd_idx;
  logic [47:0] o_data;
  logic [7:0]  o_count;
  logic        o_err;
  logic        o_drop;
  logic [15:0] o_pkt_cnt;
  logic [15:0] o_err_cnt;

  udp_box_packer dut (
    .clk(clk), .rstn(rstn),
    .udp_valid(udp_valid), .udp_data(udp_data),
    .udp_last(udp_last), .vsync(vsync),
    .rd_idx(rd_idx), .o_data(o_data),
    .o_count(o_count), .o_err(o_err),
    .o_drop(o_drop), .o_pkt_cnt(o_pkt_cnt),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_err = 0;
  int n_drop = 0;
  int n_commit = 0;
  int e0, d0;

  logic [7:0]  pkt [0:127];
  logic [47:0] recs_cur [0:15];
  logic [47:0] back_m [0:15];
  logic [47:0] disp [0:15];
  int          back_cnt = 0;
  int          disp_cnt = 0;
  bit          pend_m = 0;
  logic [47:0] exp_q [$];

  always @(negedge clk) begin
    if (o_err === 1'b1) n_err++;
    if (o_drop === 1'b1) n_drop++;
  end

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic make_pkt(int n);
    logic [47:0] rec;
    logic [7:0]  v;
    pkt[0] = 8'hA5;
    pkt[1] = 8'(n);
    for (int r = 0; r < n; r++) begin
      rec = '0;
      for (int b = 0; b < 6; b++) begin
        v = 8'($urandom);
        pkt[2 + r*6 + b] = v;
        rec = {rec[39:0], v};
      end
      recs_cur[r] = rec;
    end
  endtask

  task automatic send(int len, bit with_last, bit vs_last);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      udp_valid = 1'b1;
      udp_data  = pkt[i];
      udp_last  = with_last && (i == len - 1);
      vsync     = vs_last && (i == len - 1);
    end
  endtask

  task automatic idle(int c);
    repeat (c) begin
      @(negedge clk);
      udp_valid = 1'b0;
      udp_last  = 1'b0;
      vsync     = 1'b0;
    end
  endtask

  task automatic commit_m(int n);
    for (int i = 0; i < n; i++) back_m[i] = recs_cur[i];
    back_cnt = n;
    pend_m = 1;
    n_commit++;
  endtask

  task automatic vsync_pulse(string tag);
    @(negedge clk);
    udp_valid = 1'b0;
    udp_last  = 1'b0;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    if (pend_m) begin
      for (int i = 0; i < 16; i++) disp[i] = back_m[i];
      disp_cnt = back_cnt;
      pend_m = 0;
    end
    chk(tag, 64'(o_count), 64'(disp_cnt));
  endtask

  task automatic rd(int idx);
    @(negedge clk);
    rd_idx = 4'(idx);
    exp_q.push_back((idx < disp_cnt) ? disp[idx] : 48'h0);
    @(negedge clk);
    chk($sformatf("rd%0d", idx), 64'(o_data),
        64'(exp_q.pop_front()));
  endtask

  task automatic snap();
    e0 = n_err;
    d0 = n_drop;
  endtask

  initial begin
    rstn = 1'b0;
    udp_valid = 1'b0;
    udp_data = '0;
    udp_last = 1'b0;
    vsync = 1'b0;
    rd_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", 64'(o_count), 64'h0);
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_err", 64'(o_err), 64'h0);
    chk("rst_drop", 64'(o_drop), 64'h0);
    chk("rst_pkt", 64'(o_pkt_cnt), 64'h0);
    rstn = 1'b1;
    idle(2);

    // valid two-record packet
    snap();
    make_pkt(2);
    send(14, 1, 0);
    commit_m(2);
    idle(3);
    chk("a_err", 64'(n_err - e0), 64'h0);
    vsync_pulse("a_count");
    rd(0);
    rd(1);
    rd(2);
    rd(15);

    // bad magic
    snap();
    pkt[0] = 8'h5A;
    for (int i = 1; i < 8; i++) pkt[i] = 8'(i);
    send(8, 1, 0);
    idle(3);
    chk("magic_err", 64'(n_err - e0), 64'h1);
    vsync_pulse("magic_count");

    // N too large, drained, then a good packet
    snap();
    pkt[0] = 8'hA5;
    pkt[1] = 8'd17;
    for (int i = 2; i < 10; i++) pkt[i] = 8'hA5;
    send(10, 1, 0);
    make_pkt(3);
    send(20, 1, 0);
    commit_m(3);
    idle(3);
    chk("n17_err", 64'(n_err - e0), 64'h1);
    vsync_pulse("b_count");
    rd(0);
    rd(2);
    rd(3);

    // truncated on byte 9
    snap();
    make_pkt(2);
    send(9, 1, 0);
    idle(3);
    chk("trunc_err", 64'(n_err - e0), 64'h1);
    vsync_pulse("trunc_count");

    // one byte too long
    snap();
    make_pkt(1);
    pkt[8] = 8'h33;
    send(9, 1, 0);
    idle(3);
    chk("over_err", 64'(n_err - e0), 64'h1);
    vsync_pulse("over_count");
    rd(1);

    // back-to-back: second packet dropped
    snap();
    make_pkt(1);
    send(8, 1, 0);
    commit_m(1);
    make_pkt(4);
    send(26, 1, 0);
    idle(3);
    chk("drop_cnt", 64'(n_drop - d0), 64'h1);
    chk("drop_err", 64'(n_err - e0), 64'h0);
    vsync_pulse("c_count");
    rd(0);
    rd(1);

    // commit in the vsync cycle: no swap yet
    make_pkt(2);
    send(14, 1, 1);
    idle(1);
    chk("same_noswap", 64'(o_count), 64'(disp_cnt));
    commit_m(2);
    idle(2);
    vsync_pulse("same_swap");
    rd(1);

    // reset mid-payload
    rd(0);
    make_pkt(3);
    send(7, 0, 0);
    @(negedge clk);
    udp_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_count", 64'(o_count), 64'h0);
    chk("mid_data", 64'(o_data), 64'h0);
    chk("mid_err", 64'(o_err), 64'h0);
    disp_cnt = 0;
    pend_m = 0;
    @(negedge clk);
    rstn = 1'b1;
    rd(0);
    make_pkt(2);
    send(14, 1, 0);
    commit_m(2);
    idle(2);
    vsync_pulse("post_count");
    rd(0);
    rd(1);

`ifdef UDP_BOX_PACKER_STATS_EN
    chk("pkt_cnt", 64'(o_pkt_cnt), 64'(1));
`else
    chk("pkt_cnt", 64'(o_pkt_cnt), 64'h0);
    chk("err_cnt", 64'(o_err_cnt), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
